// File: rtl/zx_pkg.sv
// Shared definitions for the refresh-slot prefetcher: FSM state type and
// default SDRAM read latency.
package zx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    READ      = 2'd2,
    DONE      = 2'd3
  } pf_state_t;

  localparam int PF_ACK_DELAY_DEFAULT = 7;

  // Width of the read-latency down-counter; covers ACK_DELAY up to 15.
  localparam int PF_CNT_W = 4;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with combinational head read, flush, and saturating occupancy.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] LVL_FULL = (PW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);
  assign level = level_q;
  // Head byte reads as zero while empty so reset and flush present a clean value.
  assign dout  = empty ? 8'h00 : mem[rd_ptr_q];

  // Next-state for pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + (PW + 1)'(1);
        2'b01:   level_d = level_q - (PW + 1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates the read.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rfsh_prefetch.sv
// Streams bytes from SDRAM into a FIFO, one fetch per CPU refresh slot.
// A fetch survives only if nrfsh stays low until the read data is due.
module rfsh_prefetch
  import zx_pkg::*;
#(
  parameter int AW        = 25,
  parameter int DEPTH     = 8,
  parameter int ACK_DELAY = PF_ACK_DELAY_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [AW-1:0]           start_addr,
  input  logic [AW-1:0]           length,
  input  logic                    nrfsh,
  output logic                    mem_rd,
  output logic [AW-1:0]           mem_addr,
  input  logic [7:0]              mem_din,
  input  logic                    pop,
  output logic [7:0]              dout,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    done
);

  pf_state_t             state_q, state_d;
  logic                  nrfsh_q;
  logic [PF_CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         rem_q, rem_d;
  logic                  mem_rd_q, mem_rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  slot_edge;
  logic                  fifo_push;
  logic                  fifo_flush;
  logic                  fifo_full;

  assign mem_rd   = mem_rd_q;
  assign mem_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign full     = fifo_full;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pop),
    .flush (fifo_flush),
    .din   (mem_din),
    .dout  (dout),
    .empty (empty),
    .full  (fifo_full),
    .level (level)
  );

  // Fetch sequencing: start restarts the stream from any state; otherwise
  // a refresh falling edge launches a read that either completes after
  // ACK_DELAY cycles or is abandoned if nrfsh rises first.
  always_comb begin
    slot_edge  = nrfsh_q & ~nrfsh;
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mem_rd_d   = mem_rd_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (start) begin
      fifo_flush = 1'b1;
      addr_d     = start_addr;
      rem_d      = length;
      cnt_d      = '0;
      mem_rd_d   = 1'b0;
      state_d    = (length == '0) ? DONE : WAIT_SLOT;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        WAIT_SLOT: begin
          if (slot_edge && !fifo_full && (rem_q != '0)) begin
            state_d = READ;
            cnt_d   = PF_CNT_W'(ACK_DELAY);
          end
        end
        READ: begin
          if (cnt_q == PF_CNT_W'(1)) begin
            fifo_push = 1'b1;
            addr_d    = addr_q + AW'(1);
            rem_d     = rem_q - AW'(1);
            cnt_d     = '0;
            mem_rd_d  = 1'b0;
            state_d   = (rem_q == AW'(1)) ? DONE : WAIT_SLOT;
          end else if (nrfsh) begin
            // Slot closed before data was due: retry the same address later.
            cnt_d    = '0;
            mem_rd_d = 1'b0;
            state_d  = WAIT_SLOT;
          end else begin
            cnt_d    = cnt_q - PF_CNT_W'(1);
            mem_rd_d = 1'b1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == WAIT_SLOT) || (state_d == READ);
    done_d = (state_d == DONE);
  end

  // State and registered outputs; reset clears mem_rd without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      nrfsh_q  <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      mem_rd_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      nrfsh_q  <= nrfsh;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      mem_rd_q <= mem_rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: doc/rfsh_prefetch.md
RFSH_PREFETCH -- requirements
Module: rfsh_prefetch

Interface
REQ-001 Parameter AW, default 25, SDRAM byte address width.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, 2..64.
REQ-003 Parameter ACK_DELAY, default 7, SDRAM read latency in clk cycles; range 2..15.
REQ-004 clk  input  1  system clock (28 MHz domain). One clock only.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that begins a stream at start_addr for length bytes.
REQ-007 start_addr  input  AW  first byte address.
REQ-008 length  input  AW  byte count; 0 is legal.
REQ-009 nrfsh  input  1  CPU refresh strobe, active-low; its falling edge opens an SDRAM slot.
REQ-010 mem_rd  output  1  SDRAM read request.
REQ-011 mem_addr  output  AW  SDRAM address.
REQ-012 mem_din  input  8  SDRAM read data.
REQ-013 pop  input  1  consumer removes the head byte.
REQ-014 dout  output  8  head byte, valid while !empty.
REQ-015 empty, full  output  1 each  FIFO status.
REQ-016 level  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-017 busy, done  output  1 each  stream in progress / stream complete.

Function
REQ-018 The block SHALL register nrfsh into nrfsh_q; slot_edge = nrfsh_q & !nrfsh.
REQ-019 The FSM SHALL have states IDLE, WAIT_SLOT, READ and DONE.
- IDLE -> WAIT_SLOT on start with length != 0.
- IDLE -> DONE on start with length == 0.
REQ-020 In WAIT_SLOT, a slot_edge with !full and remaining != 0 SHALL move the FSM to READ, load cnt = ACK_DELAY, and assert mem_rd from the next cycle.
REQ-021 In READ, cnt SHALL decrement each cycle; in the cycle where cnt == 1, mem_din SHALL be pushed into the FIFO, mem_addr incremented mod 2^AW, and remaining decremented.
- The FSM then moves to DONE if remaining becomes 0, otherwise to WAIT_SLOT.
- mem_rd deasserts the following cycle.
REQ-022 If nrfsh returns high while in READ before cnt == 1, the fetch SHALL be aborted: nothing is pushed, the address is unchanged, mem_rd drops, and the FSM returns to WAIT_SLOT to retry the same address.
REQ-023 While full, slot edges SHALL be ignored; no fetch is issued.
REQ-024 A pop while empty SHALL be ignored. Push and pop in the same cycle SHALL leave level unchanged.
REQ-025 A start in any state SHALL flush the FIFO, abort any READ, and reload address and remaining. Start takes priority over a simultaneous push or pop.
REQ-026 busy = state in {WAIT_SLOT, READ}; done = state == DONE; DONE holds until the next start.
REQ-027 dout SHALL be the combinational read of the head entry, so it has zero-cycle latency after a push becomes visible.
REQ-028 Pointers SHALL be $clog2(DEPTH) bits and wrap naturally. level SHALL saturate at DEPTH, with full = (level == DEPTH).

Reset
REQ-029 On reset, the block SHALL enter IDLE with:
- mem_rd = 0, mem_addr = 0;
- level = 0, empty = 1, full = 0;
- busy = 0, done = 0;
- dout = 0 and nrfsh_q = 1.
REQ-030 Reset asserted mid-READ SHALL drop mem_rd asynchronously. No push occurs.

Structure
REQ-031 The shared package zx_pkg SHALL hold the state enum pf_state_t and the constant PF_ACK_DELAY_DEFAULT = 7.
REQ-032 The FIFO SHALL be the sub-module byte_fifo (parameters DEPTH; ports clk, reset, push, pop, flush, din, dout, empty, full, level).

Verification
REQ-033 start_addr=0x1000, length=3, with nrfsh pulsed low every 20 cycles -> the FIFO receives mem_din at 0x1000, 0x1001 and 0x1002, each mem_rd lasts 6 cycles, and done rises after the third push.
REQ-034 DEPTH=8, length=12, no pops -> level stops at 8, full=1, and no mem_rd is issued on further slots. After 1 pop, exactly one fetch at address start+8 occurs on the next slot.
REQ-035 nrfsh rises 3 cycles into a READ at 0x2000 -> no push, and the next slot re-reads 0x2000.
REQ-036 start while level=5 during a READ -> level=0 next cycle, mem_rd=0, and the next fetch uses the new start_addr.
REQ-037 length=0 -> done=1 one cycle after start, with no mem_rd. Also, start_addr = 2^AW-1 with length=2 -> the second fetch is at 0.
REQ-038 Assert reset during READ with level=4 -> all outputs reach their REQ-029 values immediately, without waiting for a clk edge.
